// File: rtl/fakernet_event_writer.sv
// Fakernet event writer: turns a valid/ready/last word stream into one committed buffer event per packet.
// Latency: accepted beat -> event_write 1 cycle; accepted last beat -> event_commit 2 cycles.
// Backpressure: s_ready only in FILL/DROP; a new event waits for event_free, then a holdoff after each commit.
module fakernet_event_writer #(
  parameter int MAX_WORDS   = 1024,
  parameter int HOLDOFF_CYC = 4
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        enable,
  input  logic [31:0] s_data,
  input  logic        s_valid,
  input  logic        s_last,
  output logic        s_ready,
  output logic [31:0] event_word,
  output logic [9:0]  event_offset,
  output logic        event_write,
  output logic [10:0] event_commit_len,
  output logic        event_commit,
  input  logic        event_free,
  input  logic        event_reset,
  output logic        busy,
  output logic [15:0] evt_count,
  output logic [15:0] trunc_count
);

  typedef enum logic [2:0] {IDLE, WAIT_FREE, FILL, COMMIT, DROP, HOLDOFF} state_t;

  localparam logic [10:0] LAST_OFF  = 11'(MAX_WORDS - 1);
  localparam logic [3:0]  HOLD_LAST = 4'(HOLDOFF_CYC - 1);

  state_t      state;
  logic [10:0] wcnt;
  logic [3:0]  hcnt;
  logic        trunc;
  logic        write_q;
  logic        commit_q;
  logic        beat;

  assign s_ready = (state == FILL) || (state == DROP);
  assign beat    = s_valid && s_ready;
  assign busy    = (state != IDLE) && (state != WAIT_FREE);

  // An abort must suppress a strobe already registered for this cycle.
  assign event_write  = write_q  && !event_reset;
  assign event_commit = commit_q && !event_reset;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state            <= IDLE;
      wcnt             <= '0;
      hcnt             <= '0;
      trunc            <= 1'b0;
      write_q          <= 1'b0;
      commit_q         <= 1'b0;
      event_word       <= '0;
      event_offset     <= '0;
      event_commit_len <= '0;
      evt_count        <= '0;
      trunc_count      <= '0;
    end else begin
      write_q  <= 1'b0;
      commit_q <= 1'b0;
      if (event_reset) begin
        wcnt  <= '0;
        hcnt  <= '0;
        trunc <= 1'b0;
        // The rest of an unfinished event must be drained before the next one starts.
        if ((state == FILL || state == DROP) && !(beat && s_last))
          state <= DROP;
        else
          state <= WAIT_FREE;
      end else begin
        case (state)
          IDLE: begin
            if (enable) state <= WAIT_FREE;
          end
          WAIT_FREE: begin
            if (!enable)         state <= IDLE;
            else if (event_free) state <= FILL;
          end
          FILL: begin
            if (beat) begin
              write_q      <= 1'b1;
              event_word   <= s_data;
              event_offset <= wcnt[9:0];
              wcnt         <= wcnt + 11'd1;
              if (s_last) begin
                state <= COMMIT;
              end else if (wcnt == LAST_OFF) begin
                state <= COMMIT;
                trunc <= 1'b1;
              end
            end
          end
          COMMIT: begin
            commit_q         <= 1'b1;
            event_commit_len <= wcnt;
            evt_count        <= evt_count + 16'd1;
            if (trunc && trunc_count != 16'hFFFF) trunc_count <= trunc_count + 16'd1;
            wcnt  <= '0;
            hcnt  <= '0;
            trunc <= 1'b0;
            state <= trunc ? DROP : HOLDOFF;
          end
          DROP: begin
            if (beat && s_last) begin
              hcnt  <= '0;
              state <= HOLDOFF;
            end
          end
          HOLDOFF: begin
            wcnt <= '0;
            if (hcnt == HOLD_LAST) state <= WAIT_FREE;
            else                   hcnt  <= hcnt + 4'd1;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fakernet_event_writer.sv
// Bench for fakernet_event_writer: cycle table for normal events and holdoff, directed sequences for
// truncation, free backpressure, abort, enable drop and asynchronous reset.
module tb_fakernet_event_writer;

  logic        clk = 1'b0;
  logic        rstn;
  logic        enable;
  logic [31:0] s_data;
  logic        s_valid;
  logic        s_last;
  logic        s_ready;
  logic [31:0] event_word;
  logic [9:0]  event_offset;
  logic        event_write;
  logic [10:0] event_commit_len;
  logic        event_commit;
  logic        event_free;
  logic        event_reset;
  logic        busy;
  logic [15:0] evt_count;
  logic [15:0] trunc_count;

  int errors = 0;
  int checks = 0;

  fakernet_event_writer #(.MAX_WORDS(16), .HOLDOFF_CYC(4)) dut (
    .clk(clk), .rstn(rstn), .enable(enable),
    .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready),
    .event_word(event_word), .event_offset(event_offset), .event_write(event_write),
    .event_commit_len(event_commit_len), .event_commit(event_commit),
    .event_free(event_free), .event_reset(event_reset),
    .busy(busy), .evt_count(evt_count), .trunc_count(trunc_count)
  );

  always #5 clk = ~clk;

  // Passive record of every write and commit seen on the buffer port.
  logic [9:0]  wr_off_q[$];
  logic [31:0] wr_dat_q[$];
  int          cm_n = 0;
  logic [10:0] cm_len = '0;
  int          bad_n = 0;

  always @(negedge clk) begin
    if (rstn) begin
      if (event_write) begin
        wr_off_q.push_back(event_offset);
        wr_dat_q.push_back(event_word);
        if (event_offset > 10'd15) bad_n++;
      end
      if (event_commit) begin
        cm_n++;
        cm_len = event_commit_len;
        if (event_commit_len == 11'd0 || event_commit_len > 11'd16) bad_n++;
      end
    end
  end

  typedef struct {
    logic        en, vld;
    logic [31:0] dat;
    logic        last, free;
    logic        x_rdy, x_wr;
    logic [9:0]  x_off;
    logic [31:0] x_word;
    logic        x_cm;
    logic [10:0] x_len;
    logic [15:0] x_evt;
    logic        x_busy;
  } vec_t;

  vec_t vq[$];

  task automatic add(input int en, input int vld, input int dat, input int last, input int free,
                     input int rdy, input int wr, input int off, input int word,
                     input int cm, input int len, input int evt, input int bsy);
    vec_t v;
    v.en = 1'(en); v.vld = 1'(vld); v.dat = 32'(dat); v.last = 1'(last); v.free = 1'(free);
    v.x_rdy = 1'(rdy); v.x_wr = 1'(wr); v.x_off = 10'(off); v.x_word = 32'(word);
    v.x_cm = 1'(cm); v.x_len = 11'(len); v.x_evt = 16'(evt); v.x_busy = 1'(bsy);
    vq.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Present one beat and hold it until accepted (bounded).
  task automatic send(input logic [31:0] d, input logic l);
    int t;
    t = 0;
    s_valid = 1'b1; s_data = d; s_last = l;
    @(negedge clk);
    while (!s_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    check($sformatf("send_ready_%0h", d), 32'(s_ready), 32'd1);
    @(posedge clk); #1;
    s_valid = 1'b0; s_last = 1'b0; s_data = '0;
  endtask

  initial begin
    int wb;
    int cb;
    int rdy_hits;
    rstn = 1'b0; enable = 1'b0; s_data = '0; s_valid = 1'b0; s_last = 1'b0;
    event_free = 1'b0; event_reset = 1'b0;

    // Rows: en vld dat last free | rdy wr off word cm len evt busy
    add(1,0,0,0,1,     0,0,0,0,     0,0,0,0);
    add(1,0,0,0,1,     0,0,0,0,     0,0,0,0);
    add(1,1,'hA0,0,1,  1,0,0,0,     0,0,0,1);
    add(1,1,'hA1,0,1,  1,1,0,'hA0,  0,0,0,1);
    add(1,1,'hA2,0,1,  1,1,1,'hA1,  0,0,0,1);
    add(1,1,'hA3,1,1,  1,1,2,'hA2,  0,0,0,1);
    add(1,0,0,0,1,     0,1,3,'hA3,  0,0,0,1);
    add(1,0,0,0,1,     0,0,0,0,     1,4,1,1);
    for (int k = 0; k < 3; k++) add(1,0,0,0,1, 0,0,0,0, 0,0,1,1);
    add(1,0,0,0,1,     0,0,0,0,     0,0,1,0);
    add(1,1,'h55,1,1,  1,0,0,0,     0,0,1,1);
    add(1,0,0,0,1,     0,1,0,'h55,  0,0,1,1);
    add(1,1,'h66,1,1,  0,0,0,0,     1,1,2,1);
    for (int k = 0; k < 3; k++) add(1,1,'h66,1,1, 0,0,0,0, 0,0,2,1);
    add(1,1,'h66,1,1,  0,0,0,0,     0,0,2,0);
    add(1,1,'h66,1,1,  1,0,0,0,     0,0,2,1);
    add(1,0,0,0,1,     0,1,0,'h66,  0,0,2,1);
    add(0,0,0,0,1,     0,0,0,0,     1,1,3,1);
    for (int k = 0; k < 3; k++) add(0,0,0,0,1, 0,0,0,0, 0,0,3,1);
    add(0,0,0,0,1,     0,0,0,0,     0,0,3,0);
    add(0,0,0,0,1,     0,0,0,0,     0,0,3,0);
    add(0,0,0,0,1,     0,0,0,0,     0,0,3,0);

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_ready",  32'(s_ready), 0);
    check("rst_write",  32'(event_write), 0);
    check("rst_commit", 32'(event_commit), 0);
    check("rst_busy",   32'(busy), 0);
    check("rst_evt",    32'(evt_count), 0);
    check("rst_trunc",  32'(trunc_count), 0);
    check("rst_word",   event_word, 0);
    @(posedge clk); #1;
    rstn = 1'b1;

    // Normal 4-word event, single-word event, holdoff gating, enable drop to idle
    for (int i = 0; i < vq.size(); i++) begin
      @(posedge clk); #1;
      enable = vq[i].en; s_valid = vq[i].vld; s_data = vq[i].dat;
      s_last = vq[i].last; event_free = vq[i].free;
      @(negedge clk);
      check($sformatf("row%0d_rdy", i),  32'(s_ready),      32'(vq[i].x_rdy));
      check($sformatf("row%0d_wr", i),   32'(event_write),  32'(vq[i].x_wr));
      check($sformatf("row%0d_cm", i),   32'(event_commit), 32'(vq[i].x_cm));
      check($sformatf("row%0d_evt", i),  32'(evt_count),    32'(vq[i].x_evt));
      check($sformatf("row%0d_busy", i), 32'(busy),         32'(vq[i].x_busy));
      if (vq[i].x_wr) begin
        check($sformatf("row%0d_off", i),  32'(event_offset), 32'(vq[i].x_off));
        check($sformatf("row%0d_word", i), event_word,        vq[i].x_word);
      end
      if (vq[i].x_cm)
        check($sformatf("row%0d_len", i), 32'(event_commit_len), 32'(vq[i].x_len));
    end
    check("tbl_trunc", 32'(trunc_count), 0);

    // Truncation: 20 beats into a 16-word buffer
    @(posedge clk); #1;
    enable = 1'b1; event_free = 1'b1;
    wb = wr_off_q.size(); cb = cm_n;
    for (int i = 0; i < 20; i++) send(32'h100 + 32'(i), i == 19);
    repeat (3) @(posedge clk); #1;
    check("tr_writes", 32'(wr_off_q.size() - wb), 16);
    check("tr_commits", 32'(cm_n - cb), 1);
    check("tr_len", 32'(cm_len), 16);
    check("tr_count", 32'(trunc_count), 1);
    check("tr_evt", 32'(evt_count), 4);
    for (int i = 0; i < 16 && wb + i < wr_off_q.size(); i++) begin
      check($sformatf("tr_off%0d", i), 32'(wr_off_q[wb+i]), 32'(i));
      check($sformatf("tr_dat%0d", i), wr_dat_q[wb+i], 32'h100 + 32'(i));
    end

    // Buffer not free: stream must stall, then start the cycle after free rises
    event_free = 1'b0;
    s_valid = 1'b1; s_data = 32'hB0; s_last = 1'b1;
    wb = wr_off_q.size(); cb = cm_n;
    rdy_hits = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (s_ready) rdy_hits++;
    end
    check("nf_ready_hits", 32'(rdy_hits), 0);
    check("nf_writes", 32'(wr_off_q.size() - wb), 0);
    @(posedge clk); #1;
    event_free = 1'b1;
    @(negedge clk);
    check("nf_ready_same", 32'(s_ready), 0);
    @(negedge clk);
    check("nf_ready_next", 32'(s_ready), 1);
    @(posedge clk); #1;
    s_valid = 1'b0; s_last = 1'b0;
    repeat (3) @(posedge clk); #1;
    check("nf_writes2", 32'(wr_off_q.size() - wb), 1);
    if (wr_off_q.size() > wb) check("nf_word", wr_dat_q[wb], 32'hB0);
    check("nf_len", 32'(cm_len), 1);
    check("nf_evt", 32'(evt_count), 5);

    // Abort after 3 of 8 beats: pending write cancelled, remainder drained
    wb = wr_off_q.size(); cb = cm_n;
    for (int i = 0; i < 3; i++) send(32'hC0 + 32'(i), 1'b0);
    event_reset = 1'b1;
    @(negedge clk);
    check("ab_write_gated", 32'(event_write), 0);
    @(posedge clk); #1;
    event_reset = 1'b0;
    for (int i = 3; i < 8; i++) send(32'hC0 + 32'(i), i == 7);
    check("ab_writes", 32'(wr_off_q.size() - wb), 2);
    check("ab_commits", 32'(cm_n - cb), 0);
    send(32'hD0, 1'b0);
    send(32'hD1, 1'b1);
    repeat (3) @(posedge clk); #1;
    check("ab_writes2", 32'(wr_off_q.size() - wb), 4);
    if (wr_off_q.size() >= wb + 4) begin
      check("ab_off0", 32'(wr_off_q[wb+2]), 0);
      check("ab_dat0", wr_dat_q[wb+2], 32'hD0);
      check("ab_off1", 32'(wr_off_q[wb+3]), 1);
      check("ab_dat1", wr_dat_q[wb+3], 32'hD1);
    end
    check("ab_commits2", 32'(cm_n - cb), 1);
    check("ab_len", 32'(cm_len), 2);
    check("ab_evt", 32'(evt_count), 6);

    // enable dropped mid-event: event completes, then idle
    cb = cm_n;
    send(32'hE0, 1'b0);
    send(32'hE1, 1'b0);
    enable = 1'b0;
    send(32'hE2, 1'b1);
    repeat (3) @(posedge clk); #1;
    check("en_commits", 32'(cm_n - cb), 1);
    check("en_len", 32'(cm_len), 3);
    check("en_evt", 32'(evt_count), 7);
    s_valid = 1'b1; s_data = 32'hEE; s_last = 1'b1;
    rdy_hits = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (s_ready) rdy_hits++;
    end
    check("en_idle_ready", 32'(rdy_hits), 0);
    check("en_idle_busy", 32'(busy), 0);
    @(posedge clk); #1;
    s_valid = 1'b0; s_last = 1'b0;

    // Asynchronous reset in the middle of FILL
    enable = 1'b1;
    send(32'hF0, 1'b0);
    check("ar_pre_write", 32'(event_write), 1);
    #2 rstn = 1'b0;
    #1;
    check("ar_ready",  32'(s_ready), 0);
    check("ar_write",  32'(event_write), 0);
    check("ar_word",   event_word, 0);
    check("ar_off",    32'(event_offset), 0);
    check("ar_commit", 32'(event_commit), 0);
    check("ar_len",    32'(event_commit_len), 0);
    check("ar_busy",   32'(busy), 0);
    check("ar_evt",    32'(evt_count), 0);
    check("ar_trunc",  32'(trunc_count), 0);
    check("bounds", 32'(bad_n), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
